// File: rtl/risc16_pkg.sv
// Shared RiSC-16 control encodings: opcodes, ALU functions, mux codes and sequencer states.
// Used by both the multi-cycle sequencer and the combinational control unit.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam logic [1:0] FUNC_ADD   = 2'b00;
  localparam logic [1:0] FUNC_NAND  = 2'b01;
  localparam logic [1:0] FUNC_PASS1 = 2'b10;

  localparam logic [1:0] MUXPC_PC1  = 2'b00;
  localparam logic [1:0] MUXPC_BR   = 2'b01;
  localparam logic [1:0] MUXPC_REGB = 2'b10;

  localparam logic [1:0] MUXTGT_ALU = 2'b00;
  localparam logic [1:0] MUXTGT_MEM = 2'b01;
  localparam logic [1:0] MUXTGT_PC1 = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
  } seq_state_e;

  function automatic logic reads_ra(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory (slave).
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  import risc16_pkg::*;

  logic [2:0]       opcode;
  logic             eq;
  logic             mem_ready;
  logic             halt_req;
  logic             mem_req;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       func_alu;
  logic             mux_alu1;
  logic             mux_alu2;
  logic             mux_rf;
  logic [1:0]       mux_pc;
  logic [1:0]       mux_tgt;
  logic             we_rf;
  logic             we_dmem;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, eq, mem_ready, halt_req,
    output mem_req, mem_addr_sel, ir_we, pc_we, func_alu, mux_alu1, mux_alu2,
           mux_rf, mux_pc, mux_tgt, we_rf, we_dmem, halted, error, retired
  );

  modport slave (
    output opcode, eq, mem_ready, halt_req,
    input  mem_req, mem_addr_sel, ir_we, pc_we, func_alu, mux_alu1, mux_alu2,
           mux_rf, mux_pc, mux_tgt, we_rf, we_dmem, halted, error, retired
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait counter: counts cycles without mem_ready; expired_o flags the miss that hits LIMIT.
// LIMIT=0 disables expiry.
module seq_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current miss would be the LIMIT-th one; a same-cycle mem_ready keeps inc_i low.
  assign expired_o = (LIMIT > 0) && inc_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// RiSC-16 multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB against variable-latency memory,
// with halt handshake at instruction boundaries, memory-timeout trap and retired counter.
module multicycle_sequencer
  import risc16_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_sequencer_if.master  bus
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             wait_inc;
  logic             wait_expired;
  seq_state_e       boundary;

  assign boundary = bus.halt_req ? ST_HALT : ST_FETCH;
  assign wait_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;

  seq_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .inc_i     (wait_inc),
    .expired_o (wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.retired = retired_q;

  // ALU and read-port selects follow the opcode directly; they matter only once IR is valid.
  always_comb begin
    bus.func_alu = FUNC_ADD;
    bus.mux_alu1 = 1'b0;
    bus.mux_alu2 = 1'b0;
    bus.mux_rf   = reads_ra(bus.opcode);
    case (bus.opcode)
      OP_ADDI, OP_SW, OP_LW: bus.mux_alu2 = 1'b1;
      OP_NAND:               bus.func_alu = FUNC_NAND;
      OP_LUI: begin
        bus.func_alu = FUNC_PASS1;
        bus.mux_alu1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.mux_pc       = MUXPC_PC1;
    bus.mux_tgt      = MUXTGT_ALU;
    bus.we_rf        = 1'b0;
    bus.we_dmem      = 1'b0;
    bus.halted       = 1'b0;
    bus.error        = 1'b0;
    case (state_q)
      ST_BOOT:   state_d = boundary;
      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          state_d   = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (bus.opcode)
          OP_SW, OP_LW: state_d = ST_MEM;
          OP_BEQ: begin
            bus.pc_we  = 1'b1;
            bus.mux_pc = bus.eq ? MUXPC_BR : MUXPC_PC1;
            retire     = 1'b1;
            state_d    = boundary;
          end
          OP_JALR: begin
            bus.we_rf   = 1'b1;
            bus.mux_tgt = MUXTGT_PC1;
            bus.pc_we   = 1'b1;
            bus.mux_pc  = MUXPC_REGB;
            retire      = 1'b1;
            state_d     = boundary;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.we_dmem      = (bus.opcode == OP_SW);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_SW) begin
            bus.pc_we = 1'b1;
            retire    = 1'b1;
            state_d   = boundary;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        bus.we_rf   = 1'b1;
        bus.mux_tgt = (bus.opcode == OP_LW) ? MUXTGT_MEM : MUXTGT_ALU;
        bus.pc_we   = 1'b1;
        retire      = 1'b1;
        state_d     = boundary;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        if (!bus.halt_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_ERR:    bus.error = 1'b1;
      default:   state_d = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed literal scenarios, then randomized traffic
// checked every cycle against a phase-plan model of instruction execution.
module tb_multicycle_sequencer;
  import risc16_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int P_BOOT = 0, P_FETCH = 1, P_DEC = 2, P_EXE = 3, P_MEM = 4, P_WB = 5,
                 P_HALT = 6, P_ERR = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CW)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: current phase, pending phases of this instruction, memory miss count, retirements.
  int cur = P_BOOT;
  int waitc = 0;
  int plan[$];
  int unsigned m_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  task automatic model_reset();
    cur = P_BOOT;
    waitc = 0;
    plan.delete();
    m_ret = 0;
  endtask

  task automatic boundary();
    cur = bus.halt_req ? P_HALT : P_FETCH;
    waitc = 0;
  endtask

  task automatic advance();
    if (cur == P_FETCH) begin
      plan = '{P_DEC, P_EXE};
      if (bus.opcode == OP_LW) begin
        plan.push_back(P_MEM);
        plan.push_back(P_WB);
      end else if (bus.opcode == OP_SW) begin
        plan.push_back(P_MEM);
      end else if (bus.opcode != OP_BEQ && bus.opcode != OP_JALR) begin
        plan.push_back(P_WB);
      end
    end
    if (plan.size() == 0) begin
      m_ret++;
      boundary();
    end else begin
      cur = plan.pop_front();
      waitc = 0;
    end
  endtask

  task automatic model_step();
    case (cur)
      P_BOOT: boundary();
      P_HALT: if (!bus.halt_req) begin cur = P_FETCH; waitc = 0; end
      P_ERR: ;
      P_FETCH, P_MEM: begin
        if (bus.mem_ready) advance();
        else begin
          waitc++;
          if (TO != 0 && waitc >= TO) cur = P_ERR;
        end
      end
      default: advance();
    endcase
  endtask

  task automatic model_compare();
    logic [2:0] op;
    logic e_req, e_pc, e_rf, e_ir, e_wd;
    int e_mpc, e_tgt;
    op    = bus.opcode;
    e_req = (cur == P_FETCH) || (cur == P_MEM);
    e_ir  = (cur == P_FETCH) && bus.mem_ready;
    e_wd  = (cur == P_MEM) && (op == OP_SW);
    e_pc  = ((cur == P_EXE) && (op == OP_BEQ || op == OP_JALR)) ||
            ((cur == P_MEM) && (op == OP_SW) && bus.mem_ready) || (cur == P_WB);
    e_rf  = ((cur == P_EXE) && (op == OP_JALR)) || (cur == P_WB);
    e_mpc = (op == OP_JALR) ? 2 : ((op == OP_BEQ && bus.eq) ? 1 : 0);
    e_tgt = (op == OP_JALR) ? 2 : ((op == OP_LW) ? 1 : 0);
    chk("mem_req", bus.mem_req, e_req);
    chk("ir_we", bus.ir_we, e_ir);
    chk("we_dmem", bus.we_dmem, e_wd);
    chk("pc_we", bus.pc_we, e_pc);
    chk("we_rf", bus.we_rf, e_rf);
    chk("halted", bus.halted, cur == P_HALT);
    chk("error", bus.error, cur == P_ERR);
    chk("retired", bus.retired, m_ret % (1 << CW));
    if (e_req) chk("mem_addr_sel", bus.mem_addr_sel, cur == P_MEM);
    if (e_pc) chk("mux_pc", bus.mux_pc, e_mpc);
    if (e_rf) chk("mux_tgt", bus.mux_tgt, e_tgt);
    if (cur == P_DEC) chk("mux_rf", bus.mux_rf, op == OP_SW || op == OP_BEQ);
    if ((cur == P_EXE || cur == P_MEM) && (op == OP_LW || op == OP_SW)) begin
      chk("addr func_alu", bus.func_alu, 0);
      chk("addr mux_alu2", bus.mux_alu2, 1);
    end
    if (cur == P_WB) begin
      case (op)
        OP_ADD:  begin chk("add func", bus.func_alu, 0); chk("add alu2", bus.mux_alu2, 0); chk("add alu1", bus.mux_alu1, 0); end
        OP_ADDI: begin chk("addi func", bus.func_alu, 0); chk("addi alu2", bus.mux_alu2, 1); chk("addi alu1", bus.mux_alu1, 0); end
        OP_NAND: begin chk("nand func", bus.func_alu, 1); chk("nand alu2", bus.mux_alu2, 0); chk("nand alu1", bus.mux_alu1, 0); end
        OP_LUI:  begin chk("lui func", bus.func_alu, 2); chk("lui alu1", bus.mux_alu1, 1); end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic rdy, input logic h, input logic [2:0] op, input logic e,
                       input logic rel);
    @(posedge clk);
    #1;
    if (rel) rst_n = 1'b1;
    bus.mem_ready = rdy;
    bus.halt_req  = h;
    bus.opcode    = op;
    bus.eq        = e;
    cyc++;
    #1;
    model_compare();
    model_step();
  endtask

  initial begin
    logic h;
    logic [2:0] op;
    int err_cycles;
    bus.mem_ready = 1'b0;
    bus.halt_req  = 1'b0;
    bus.opcode    = OP_ADD;
    bus.eq        = 1'b0;
    #3;
    model_reset();
    model_compare();
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset retired", bus.retired, 0);
    chk("reset halted", bus.halted, 0);
    chk("reset error", bus.error, 0);
    repeat (2) @(posedge clk);

    // boot, fetch, then add
    cycle(1, 0, OP_ADD, 0, 1); chk("boot mem_req", bus.mem_req, 0);
    cycle(1, 0, OP_ADD, 0, 0); chk("fetch mem_req", bus.mem_req, 1);
    chk("fetch addr_sel", bus.mem_addr_sel, 0); chk("fetch ir_we", bus.ir_we, 1);
    cycle(1, 0, OP_ADD, 0, 0); chk("decode we_rf", bus.we_rf, 0);
    cycle(1, 0, OP_ADD, 0, 0); chk("add exec pc_we", bus.pc_we, 0);
    cycle(1, 0, OP_ADD, 0, 0); chk("add wb we_rf", bus.we_rf, 1);
    chk("add wb pc_we", bus.pc_we, 1); chk("add wb retired", bus.retired, 0);

    // lw with three memory misses
    cycle(1, 0, OP_LW, 0, 0); chk("add retired", bus.retired, 1);
    cycle(1, 0, OP_LW, 0, 0);
    cycle(1, 0, OP_LW, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, OP_LW, 0, 0);
      chk("lw wait mem_req", bus.mem_req, 1); chk("lw wait addr_sel", bus.mem_addr_sel, 1);
    end
    cycle(1, 0, OP_LW, 0, 0); chk("lw done mem_req", bus.mem_req, 1); chk("lw mem we_rf", bus.we_rf, 0);
    cycle(1, 0, OP_LW, 0, 0); chk("lw wb we_rf", bus.we_rf, 1);
    chk("lw wb mux_tgt", bus.mux_tgt, 1); chk("lw wb pc_we", bus.pc_we, 1);

    // beq taken / not taken
    cycle(1, 0, OP_BEQ, 1, 0); chk("lw retired", bus.retired, 2);
    cycle(1, 0, OP_BEQ, 1, 0); chk("beq mux_rf", bus.mux_rf, 1);
    cycle(1, 0, OP_BEQ, 1, 0); chk("beq1 pc_we", bus.pc_we, 1); chk("beq1 mux_pc", bus.mux_pc, 1);
    cycle(1, 0, OP_BEQ, 0, 0); chk("beq retired", bus.retired, 3);
    cycle(1, 0, OP_BEQ, 0, 0);
    cycle(1, 0, OP_BEQ, 0, 0); chk("beq0 pc_we", bus.pc_we, 1); chk("beq0 mux_pc", bus.mux_pc, 0);

    // sw with halt raised in EXEC
    cycle(1, 0, OP_SW, 0, 0);
    cycle(1, 0, OP_SW, 0, 0);
    cycle(1, 1, OP_SW, 0, 0); chk("sw exec pc_we", bus.pc_we, 0); chk("sw exec halted", bus.halted, 0);
    cycle(1, 1, OP_SW, 0, 0); chk("sw we_dmem", bus.we_dmem, 1); chk("sw pc_we", bus.pc_we, 1);
    cycle(1, 1, OP_SW, 0, 0); chk("halt halted", bus.halted, 1); chk("halt mem_req", bus.mem_req, 0);
    chk("sw retired", bus.retired, 5);
    cycle(1, 0, OP_LW, 0, 0); chk("halt release halted", bus.halted, 1);
    cycle(1, 0, OP_LW, 0, 0); chk("resume mem_req", bus.mem_req, 1); chk("resume halted", bus.halted, 0);

    // reset while lw waits in MEM
    cycle(1, 0, OP_LW, 0, 0);
    cycle(1, 0, OP_LW, 0, 0);
    cycle(0, 0, OP_LW, 0, 0); chk("mid-mem mem_req", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1 chk("reset mid-mem mem_req", bus.mem_req, 0);
    model_reset();

    // ready on the last allowed cycle wins, then a real timeout
    cycle(0, 0, OP_ADD, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, OP_ADD, 0, 0);
    cycle(1, 0, OP_ADD, 0, 0); chk("limit ready ir_we", bus.ir_we, 1);
    cycle(1, 0, OP_ADD, 0, 0); chk("limit ready error", bus.error, 0);
    cycle(1, 0, OP_ADD, 0, 0);
    cycle(1, 0, OP_ADD, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, OP_ADD, 0, 0); chk("timeout wait mem_req", bus.mem_req, 1);
    end
    cycle(0, 0, OP_ADD, 0, 0); chk("timeout error", bus.error, 1); chk("timeout mem_req", bus.mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, OP_ADD, 0, 0); chk("error sticky", bus.error, 1);
    end
    #1 rst_n = 1'b0;
    #1 chk("reset clears error", bus.error, 0);
    model_reset();
    cycle(1, 0, OP_ADD, 0, 1);

    // randomized traffic
    h = 1'b0;
    op = OP_ADD;
    err_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (cur == P_ERR) err_cycles++;
      if (err_cycles > 3 || $urandom_range(0, 299) == 0) begin
        err_cycles = 0;
        #1 rst_n = 1'b0;
        #1 model_reset();
        model_compare();
        cycle(1'($urandom_range(0, 1)), h, op, 1'b0, 1);
      end else begin
        if (cur == P_FETCH) op = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) h = ~h;
        cycle(1'($urandom_range(0, 3) != 0), h, op, 1'($urandom_range(0, 1)), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
